// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instr_fetch_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_W      = 2;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   // One fetched instruction with the byte address it was read from (64 bits).
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register FIFO holding fetched {pc, instr} pairs; entry 0 is always the head.
module fetch_fifo
   import instr_fetch_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     push_data,
   output fetch_entry_t     head,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     entry_q [FIFO_DEPTH];
   fetch_entry_t     entry_d [FIFO_DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] wr_idx;
   logic             valid_q;
   logic             valid_d;
   logic             do_pop;
   logic             do_push;

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   always_comb begin
      entry_d = entry_q;
      count_d = count_q;
      do_pop  = pop && (count_q != '0);
      do_push = push && ((count_q < CNT_W'(FIFO_DEPTH)) || do_pop);
      wr_idx  = count_q - CNT_W'(do_pop);
      if (flush) begin
         count_d = '0;
      end else begin
         if (do_pop) begin
            for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
               entry_d[i] = entry_q[i+1];
            end
         end
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (do_push && (wr_idx == CNT_W'(i))) begin
               entry_d[i] = push_data;
            end
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         entry_q <= entry_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign head  = entry_q[0];
   assign valid = valid_q;
   assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Sequential instruction fetch: PC register, redirect/fault control, 2-deep output queue.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        busy,
   output logic        fault,
   output logic [31:0] fault_pc
);

   fetch_state_e     state_q;
   fetch_state_e     state_d;
   logic [31:0]      pc_q;
   logic [31:0]      pc_d;
   logic             fault_q;
   logic             fault_d;
   logic [31:0]      fault_pc_q;
   logic [31:0]      fault_pc_d;
   logic             busy_q;
   logic             busy_d;

   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_flush;
   logic             fifo_valid;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     fifo_head;
   fetch_entry_t     fetch_entry;
   logic             misaligned;
   logic             has_room;

   assign fifo_pop    = fifo_valid && out_ready;
   assign misaligned  = (redirect_pc[1:0] != 2'b00);
   assign has_room    = (fifo_count < CNT_W'(FIFO_DEPTH)) || fifo_pop;
   assign fetch_entry = '{pc: pc_q, instr: imem_data};

   // Redirect outranks fetch; a misaligned target latches the fault and parks the block.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (redirect_valid) begin
               if (misaligned) begin
                  fault_d    = 1'b1;
                  fault_pc_d = redirect_pc;
                  fifo_flush = 1'b1;
                  state_d    = ST_FAULT;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (redirect_valid) begin
               fifo_flush = 1'b1;
               if (misaligned) begin
                  fault_d    = 1'b1;
                  fault_pc_d = redirect_pc;
                  state_d    = ST_FAULT;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (has_room) begin
               fifo_push = 1'b1;
               pc_d      = pc_q + 32'd4;
            end
         end
         ST_FAULT: begin
            fifo_flush = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
         busy_q     <= busy_d;
      end
   end

   fetch_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .push_data (fetch_entry),
      .head      (fifo_head),
      .valid     (fifo_valid),
      .count     (fifo_count)
   );

   assign imem_addr = {2'b00, pc_q[31:2]};
   assign out_valid = fifo_valid;
   assign out_instr = fifo_head.instr;
   assign out_pc    = fifo_head.pc;
   assign busy      = busy_q;
   assign fault     = fault_q;
   assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue-based reference model checked every cycle.
module tb_instr_fetch;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FAULT = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        busy;
   logic        fault;
   logic [31:0] fault_pc;

   int          n_chk  = 0;
   int          n_pass = 0;

   int          m_state;
   logic [31:0] m_pc;
   logic        m_fault;
   logic [31:0] m_fault_pc;
   ent_t        m_q [$];
   logic [31:0] acc_pc [$];
   logic [31:0] acc_instr [$];

   always #5 clk = ~clk;

   // Instruction memory content: word index XOR a fixed pattern.
   assign imem_data = imem_addr ^ 32'hA5A5_0000;

   instr_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .busy           (busy),
      .fault          (fault),
      .fault_pc       (fault_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
      return (byte_addr >> 2) ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_tick();
      bit popped;
      bit room;
      if (!reset) begin
         m_state    = M_IDLE;
         m_pc       = 32'h0;
         m_fault    = 1'b0;
         m_fault_pc = 32'h0;
         m_q.delete();
      end else begin
         popped = (m_q.size() != 0) && out_ready;
         room   = (m_q.size() < 2) || popped;
         if (popped) begin
            acc_pc.push_back(m_q[0].pc);
            acc_instr.push_back(m_q[0].instr);
            void'(m_q.pop_front());
         end
         if (m_state == M_IDLE || m_state == M_RUN) begin
            if (redirect_valid) begin
               if (redirect_pc % 4 != 0) begin
                  m_fault    = 1'b1;
                  m_fault_pc = redirect_pc;
                  m_q.delete();
                  m_state    = M_FAULT;
               end else begin
                  m_q.delete();
                  m_pc = redirect_pc;
               end
            end else if (m_state == M_IDLE) begin
               if (start) m_state = M_RUN;
            end else if (room) begin
               m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   task automatic compare();
      chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         chk("out_pc", out_pc, m_q[0].pc);
         chk("out_instr", out_instr, m_q[0].instr);
      end
      chk("busy", 32'(busy), 32'(m_state == M_RUN));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("fault_pc", fault_pc, m_fault_pc);
      chk("imem_addr", imem_addr, m_pc >> 2);
   endtask

   task automatic step();
      model_tick();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      start          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      step();
      reset = 1'b1;
      acc_pc.delete();
      acc_instr.delete();
   endtask

   task automatic chk_log(input string name, input int idx, input logic [31:0] exp_pc);
      if (acc_pc.size() > idx) begin
         chk({name, "_pc"}, acc_pc[idx], exp_pc);
         chk({name, "_instr"}, acc_instr[idx], (exp_pc >> 2) ^ 32'hA5A5_0000);
      end else begin
         chk({name, "_present"}, 32'(acc_pc.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      reset          = 1'b0;
      start          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      @(negedge clk);
      do_reset();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);

      // Streaming with decode always ready.
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      chk("lat_busy_t1", 32'(busy), 32'd1);
      chk("lat_valid_t1", 32'(out_valid), 32'd0);
      step();
      chk("lat_valid_t2", 32'(out_valid), 32'd1);
      chk("lat_pc_t2", out_pc, 32'h0);
      chk("lat_instr_t2", out_instr, 32'hA5A5_0000);
      steps(5);
      chk_log("stream0", 0, 32'h0);
      chk_log("stream1", 1, 32'h4);
      chk_log("stream2", 2, 32'h8);
      chk_log("stream3", 3, 32'hC);

      // Backpressure: queue fills, PC holds, then drains in order.
      do_reset();
      out_ready = 1'b0;
      start     = 1'b1;
      step();
      start = 1'b0;
      steps(5);
      chk("bp_imem_addr", imem_addr, 32'd2);
      chk("bp_model_count", 32'(m_q.size()), 32'd2);
      out_ready = 1'b1;
      steps(5);
      chk_log("bp0", 0, 32'h0);
      chk_log("bp1", 1, 32'h4);
      chk_log("bp2", 2, 32'h8);
      chk_log("bp3", 3, 32'hC);

      // Redirect while full with a simultaneous handshake.
      do_reset();
      out_ready = 1'b0;
      start     = 1'b1;
      step();
      start = 1'b0;
      steps(3);
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      step();
      redirect_valid = 1'b0;
      chk("rd_valid_after", 32'(out_valid), 32'd0);
      steps(4);
      chk_log("rd0", 0, 32'h0);
      chk_log("rd1", 1, 32'h100);
      chk_log("rd2", 2, 32'h104);

      // Misaligned redirect parks the block until reset.
      do_reset();
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      steps(3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0102;
      step();
      redirect_valid = 1'b0;
      chk("flt_fault", 32'(fault), 32'd1);
      chk("flt_fault_pc", fault_pc, 32'h0000_0102);
      chk("flt_busy", 32'(busy), 32'd0);
      chk("flt_valid", 32'(out_valid), 32'd0);
      start = 1'b1;
      step();
      start          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      step();
      redirect_valid = 1'b0;
      steps(3);
      chk("flt_valid_late", 32'(out_valid), 32'd0);
      chk("flt_busy_late", 32'(busy), 32'd0);
      do_reset();
      chk("flt_cleared", 32'(fault), 32'd0);
      chk("flt_pc_cleared", fault_pc, 32'h0);

      // Redirect in IDLE near the top of the address space, then wrap.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      step();
      redirect_valid = 1'b0;
      chk("idle_rd_busy", 32'(busy), 32'd0);
      chk("idle_rd_addr", imem_addr, 32'h3FFF_FFFE);
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      steps(5);
      chk_log("wrap0", 0, 32'hFFFF_FFF8);
      chk_log("wrap1", 1, 32'hFFFF_FFFC);
      chk_log("wrap2", 2, 32'h0000_0000);

      // Reset mid-run with a full queue, overriding start and redirect.
      do_reset();
      out_ready = 1'b0;
      start     = 1'b1;
      step();
      start = 1'b0;
      steps(3);
      chk("mid_count", 32'(m_q.size()), 32'd2);
      reset          = 1'b0;
      out_ready      = 1'b1;
      start          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      acc_pc.delete();
      acc_instr.delete();
      step();
      reset          = 1'b1;
      start          = 1'b0;
      redirect_valid = 1'b0;
      chk("mid_valid", 32'(out_valid), 32'd0);
      chk("mid_addr", imem_addr, 32'h0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_no_xfer", 32'(acc_pc.size()), 32'd0);
      steps(3);
      chk("mid_idle_valid", 32'(out_valid), 32'd0);
      chk("mid_idle_addr", imem_addr, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
